// File: rtl/sram_pipe.sv
// sram_pipe
//   Single-port synchronous SRAM. Requests use a valid/ready handshake, writes
//   have per-byte enables, and the read latency can be set from 1 to 4 cycles.
//   When CLEAR_EN is set, the whole array is zero-filled after every reset.
//   This memory sits behind the core's load/store unit as instruction/data
//   storage.
//
// Parameters
//   DW        data width in bits (multiple of 8)
//   DEPTH     number of DW-bit words (power of two)
//   RD_LAT    cycles from read accept to rsp_valid (1..4)
//   CLEAR_EN  1 = zero-fill the array after reset, 0 = skip the clear
//
// Ports
//   clk        clock; all logic runs on the rising edge
//   rst        synchronous reset, active-high
//   req_valid  a request is present
//   req_ready  the request is accepted when req_valid & req_ready
//   req_we     byte write enables; all zero means a read
//   req_adr    byte address; only the word-index bits are used
//   req_din    write data; byte lane i is req_din[8i+7:8i]
//   rsp_valid  one-cycle pulse per read carrying rsp_dout
//   rsp_dout   read data; holds the last returned word between pulses
//   busy       high while the post-reset clear is running

module sram_pipe #(
    parameter int DW       = 32,
    parameter int DEPTH    = 16384,
    parameter int RD_LAT   = 1,
    parameter int CLEAR_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DW/8-1:0]   req_we,
    input  logic [31:0]       req_adr,
    input  logic [DW-1:0]     req_din,
    output logic              rsp_valid,
    output logic [DW-1:0]     rsp_dout,
    output logic              busy
);

    localparam int NB    = DW / 8;
    localparam int OFS_W = $clog2(NB);
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            rd_vld_q, rd_vld_d;
    logic [DW-1:0]   rd_dat_q;

    logic [DW-1:0]   mem [DEPTH];

    logic [AW-1:0]   req_idx;
    logic            req_acc;
    logic            rd_en;
    logic [NB-1:0]   mem_wr;
    logic [AW-1:0]   mem_idx;
    logic [DW-1:0]   mem_wdata;

    // The byte offset and the bits above the word index are deliberately
    // dropped, so addresses wrap modulo DEPTH. Folding the whole address
    // here marks those bits as intentionally unconsumed.
    logic unused_adr;
    assign unused_adr = ^req_adr;

    assign req_idx = req_adr[OFS_W +: AW];

    // A request can only land on an edge where reset is low. This keeps a
    // request that coincides with a reset edge from corrupting the array or
    // leaving a response behind.
    assign req_acc = req_valid & ready_q & ~rst;

    // The single array port is shared between the clear sweep and normal
    // requests. The clear sweep owns the port for the whole CLEAR state.
    always_comb begin
        mem_wr    = '0;
        mem_idx   = req_idx;
        mem_wdata = req_din;
        rd_en     = 1'b0;
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_wr    = '1;
                mem_idx   = clr_cnt_q;
                mem_wdata = '0;
            end else if (req_acc) begin
                if (req_we != '0) begin
                    mem_wr = req_we;
                end else begin
                    rd_en = 1'b1;
                end
            end
        end
    end

    // Next-state logic for the clear sequencer. ready and busy are
    // registered copies of the next state, so both are clean flop outputs
    // and have well-defined values while reset is asserted.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rd_vld_d  = rd_en;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + AW'(1);
            if (clr_cnt_q == AW'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end
        busy_d  = (state_d == CLEAR);
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_EN != 0) ? CLEAR : RUN;
            clr_cnt_q <= '0;
            busy_q    <= (CLEAR_EN != 0);
            ready_q   <= 1'b0;
            rd_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    // Array write port. Each byte lane is written only when its enable is
    // set; the other lanes keep their contents.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_wr[b]) begin
                mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Registered array read, which forms the first latency stage. It loads
    // straight from the array so that it maps onto a block RAM output
    // register. It only loads on a read, so it holds the last word read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dat_q <= '0;
        end else if (rd_en) begin
            rd_dat_q <= mem[req_idx];
        end
    end

    // Any further latency stages. Each stage only loads data when the
    // upstream stage is valid, so rsp_dout holds its value between pulses.
    generate
        if (RD_LAT <= 1) begin : g_no_pipe
            assign rsp_valid = rd_vld_q;
            assign rsp_dout  = rd_dat_q;
        end else begin : g_pipe
            logic [RD_LAT-2:0] vld_q, vld_d;
            logic [DW-1:0]     dat_q [RD_LAT-1];
            logic [DW-1:0]     dat_d [RD_LAT-1];

            always_comb begin
                vld_d[0] = rd_vld_q;
                dat_d[0] = rd_vld_q ? rd_dat_q : dat_q[0];
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    vld_d[i] = vld_q[i-1];
                    dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int i = 0; i < RD_LAT - 1; i++) begin
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    for (int i = 0; i < RD_LAT - 1; i++) begin
                        dat_q[i] <= dat_d[i];
                    end
                end
            end

            assign rsp_valid = vld_q[RD_LAT-2];
            assign rsp_dout  = dat_q[RD_LAT-2];
        end
    endgenerate

    assign req_ready = ready_q;
    assign busy      = busy_q;

endmodule
